digital_stream_transmitter: RTL and testbench

- Serializing transmitter for the digital telemetry link carried on dCLK/dDAT/dFM: the transmit end of the three-wire stream that the digital receiver deserializes.
- Pulls parallel words through a valid/ready handshake and shifts each one out MSB-first on dDAT with a generated bit clock.
- Marks frame starts on dFM.
- Used as the on-board stimulus source for the receive path and as the transmit side when a board forwards digital data.

---
 rtl/digital_stream_transmitter.sv | 151 +++++++++++++++
 tb/tb_digital_stream_transmitter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/digital_stream_transmitter.sv
// Serial transmitter for the dCLK/dDAT/dFM digital telemetry link.
// Pulls words over valid/ready and shifts them out MSB-first with a divided bit clock.
module digital_stream_transmitter #(
  parameter int unsigned WORD_WIDTH      = 12,
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned WORDS_PER_FRAME = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] wordData,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic                  dCLK,
  output logic                  dDAT,
  output logic                  dFM,
  output logic                  underrun,
  output logic                  frameDone
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WORD_WIDTH);
  localparam int unsigned WC_W  = $clog2(WORDS_PER_FRAME);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_W-1:0]      r_div;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BIT_W-1:0]      w_bit_cnt_nxt;
  logic [WC_W-1:0]       r_word_cnt;
  logic [WC_W-1:0]       w_word_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] w_shift_nxt;
  logic                  r_dclk;
  logic                  w_dclk_nxt;
  logic                  r_dfm;
  logic                  w_dfm_nxt;

  logic                  w_div_term;
  logic                  w_bit_last;
  logic                  w_word_last;
  logic                  w_word_end;
  logic                  w_load;
  logic [WC_W-1:0]       w_word_cnt_adv;
  logic [WC_W-1:0]       w_load_word;

  // Event decode: a word ends on the dCLK 1->0 toggle of its last bit.
  always_comb begin
    w_div_term     = (r_div == DIV_W'(CLK_DIV - 1));
    w_bit_last     = (r_bit_cnt == BIT_W'(WORD_WIDTH - 1));
    w_word_last    = (r_word_cnt == WC_W'(WORDS_PER_FRAME - 1));
    w_word_end     = (r_state == S_RUN) && w_div_term && r_dclk && w_bit_last;
    w_load         = ((r_state == S_IDLE) || w_word_end) && enable;
    w_word_cnt_adv = w_word_last ? '0 : (r_word_cnt + WC_W'(1));
    w_load_word    = (r_state == S_IDLE) ? '0 : w_word_cnt_adv;
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_shift_nxt    = r_shift;
    w_dclk_nxt     = r_dclk;
    w_dfm_nxt      = r_dfm;

    case (r_state)
      S_IDLE: begin
        w_div_nxt      = '0;
        w_bit_cnt_nxt  = '0;
        w_word_cnt_nxt = '0;
        w_shift_nxt    = '0;
        w_dclk_nxt     = 1'b0;
        w_dfm_nxt      = 1'b0;
      end
      S_RUN: begin
        if (!w_div_term) begin
          w_div_nxt = r_div + DIV_W'(1);
        end else begin
          w_div_nxt = '0;
          if (!r_dclk) begin
            w_dclk_nxt = 1'b1;
          end else if (!w_bit_last) begin
            w_dclk_nxt    = 1'b0;
            w_shift_nxt   = {r_shift[WORD_WIDTH-2:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_dfm_nxt     = 1'b0;
          end else begin
            w_word_cnt_nxt = w_word_cnt_adv;
            if (!enable) begin
              w_state_nxt    = S_IDLE;
              w_dclk_nxt     = 1'b0;
              w_dfm_nxt      = 1'b0;
              w_shift_nxt    = '0;
              w_bit_cnt_nxt  = '0;
              w_word_cnt_nxt = '0;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A load restarts the bit timing; an absent word is sent as zeros.
    if (w_load) begin
      w_state_nxt   = S_RUN;
      w_shift_nxt   = wordValid ? wordData : '0;
      w_dclk_nxt    = 1'b0;
      w_div_nxt     = '0;
      w_bit_cnt_nxt = '0;
      w_dfm_nxt     = (w_load_word == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_shift    <= '0;
      r_dclk     <= 1'b0;
      r_dfm      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_dclk     <= w_dclk_nxt;
      r_dfm      <= w_dfm_nxt;
    end
  end

  // Strobes are decoded from the current state so they coincide with the load cycle.
  assign wordReady = w_load & ~rst;
  assign underrun  = w_load & ~wordValid & ~rst;
  assign frameDone = w_word_end & w_word_last & ~rst;

  assign dCLK = r_dclk;
  assign dDAT = r_shift[WORD_WIDTH-1];
  assign dFM  = r_dfm;

endmodule

// File: tb/tb_digital_stream_transmitter.sv
// Bench for digital_stream_transmitter: random traffic, enable and reset
// against a cycle-timing reference model of the serial link.
module tb_digital_stream_transmitter;

  localparam int unsigned WW  = 12;
  localparam int unsigned CD  = 4;
  localparam int unsigned WPF = 4;
  localparam int unsigned BP  = 2 * CD;
  localparam int unsigned WP  = WW * BP;

  logic          clk;
  logic          rst;
  logic          enable;
  logic [WW-1:0] wordData;
  logic          wordValid;
  logic          wordReady;
  logic          dCLK;
  logic          dDAT;
  logic          dFM;
  logic          underrun;
  logic          frameDone;

  digital_stream_transmitter #(
    .WORD_WIDTH     (WW),
    .CLK_DIV        (CD),
    .WORDS_PER_FRAME(WPF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wordData (wordData),
    .wordValid(wordValid),
    .wordReady(wordReady),
    .dCLK     (dCLK),
    .dDAT     (dDAT),
    .dFM      (dFM),
    .underrun (underrun),
    .frameDone(frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_failures = 0;
  bit checking   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: time since the current word started, word content and index in frame.
  bit          m_run  = 1'b0;
  int          m_t    = 0;
  int          m_idx  = 0;
  logic [WW-1:0] m_word = '0;
  int          n_frames = 0;
  int          n_underruns = 0;

  always @(negedge clk) begin
    if (checking) begin
      int  b;
      bit  e_clk, e_dat, e_fm, e_end, e_load, e_fd, e_ur;
      e_clk = 0; e_dat = 0; e_fm = 0; e_end = 0; e_fd = 0;
      if (m_run) begin
        b     = m_t / BP;
        e_clk = (m_t % BP) >= CD;
        e_dat = m_word[WW-1-b];
        e_fm  = (m_idx == 0) && (b == 0);
        e_end = (m_t == WP - 1);
        e_fd  = e_end && (m_idx == WPF - 1);
      end
      e_load = (!m_run || e_end) && enable && !rst;
      e_ur   = e_load && !wordValid;
      e_fd   = e_fd && !rst;

      check("dCLK", 32'(dCLK), 32'(e_clk));
      check("dDAT", 32'(dDAT), 32'(e_dat));
      check("dFM", 32'(dFM), 32'(e_fm));
      check("wordReady", 32'(wordReady), 32'(e_load));
      check("underrun", 32'(underrun), 32'(e_ur));
      check("frameDone", 32'(frameDone), 32'(e_fd));
      if (e_fd) n_frames++;
      if (e_ur) n_underruns++;

      if (rst) begin
        m_run = 0; m_idx = 0; m_t = 0;
      end else if (!m_run) begin
        if (enable) begin
          m_run = 1; m_t = 0; m_idx = 0;
          m_word = wordValid ? wordData : '0;
        end
      end else if (e_end) begin
        m_idx = (m_idx + 1) % WPF;
        if (enable) begin
          m_t = 0;
          m_word = wordValid ? wordData : '0;
        end else begin
          m_run = 0; m_idx = 0;
        end
      end else begin
        m_t++;
      end
    end
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    wordValid = 1'b1;
    wordData  = WW'(12'hA5C);

    // Reset held with enable and valid high; first load follows release.
    @(posedge clk); #1 checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // Continuous traffic over several frames with occasional underruns.
    repeat (900) begin
      @(posedge clk); #1;
      wordData  = WW'($urandom);
      wordValid = ($urandom_range(0, 7) != 0);
    end

    // Random enable drops/raises and mid-word resets.
    repeat (5000) begin
      @(posedge clk); #1;
      wordData  = WW'($urandom);
      wordValid = ($urandom_range(0, 5) != 0);
      rst       = 1'b0;
      if ($urandom_range(0, 249) == 0) enable = ~enable;
      if ($urandom_range(0, 999) == 0) rst = 1'b1;
    end

    // Finish with a clean stop so the idle state is observed.
    @(posedge clk); #1 enable = 1'b0; rst = 1'b0;
    repeat (2 * WP) @(posedge clk);
    #1;
    check("frames_seen", 32'(n_frames > 2), 32'd1);
    check("underruns_seen", 32'(n_underruns > 0), 32'd1);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
